// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define MULDIV_DIV_EN to build the divider; without it funct3 1xx finishes at once with result 0.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] SignMin = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFinish} state_e;

  state_e            state_q, state_d;
  logic              done_q;
  logic [XLEN-1:0]   result_q;
  logic [4:0]        cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   a_q;
  logic [2*XLEN-1:0] acc_q;
  logic              neg_res_q;

  logic              accept, special;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, prod;
  logic [XLEN-1:0]   fin_res;

`ifdef MULDIV_DIV_EN
  logic [XLEN-1:0]   rem_q, rem_d;
  logic              neg_rem_q;
  logic              div_zero, div_ovf, div_ok;
  logic [XLEN:0]     div_shift, div_diff;
  logic [XLEN-1:0]   quo_fin, rem_fin;
`endif

  // Operand decode and sign extraction (MULHSU: rs1 signed, rs2 unsigned)
  always_comb begin
    accept   = (state_q == StIdle) && !done_q && start && !kill;
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
               (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed && rs1_val[XLEN-1];
    b_neg    = b_signed && rs2_val[XLEN-1];
    a_mag    = a_neg ? (~rs1_val + 1'b1) : rs1_val;
    b_mag    = b_neg ? (~rs2_val + 1'b1) : rs2_val;
`ifdef MULDIV_DIV_EN
    div_zero = funct3[2] && (rs2_val == '0);
    div_ovf  = funct3[2] && !funct3[0] && (rs1_val == SignMin) && (rs2_val == '1);
    special  = div_zero || div_ovf;
`else
    special  = funct3[2];
`endif
  end

  // Iteration datapath; a_q holds the multiplicand or divisor, acc_q low half the quotient
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, a_q} & {(XLEN+1){acc_q[0]}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    div_shift = {rem_q, acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, a_q};
    div_ok    = !div_diff[XLEN];
    rem_d     = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
`endif
  end

  // Sign correction and result select
  always_comb begin
    prod = neg_res_q ? (~acc_q + 1'b1) : acc_q;
`ifdef MULDIV_DIV_EN
    quo_fin = neg_res_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
    rem_fin = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
`endif
    fin_res = '0;
    case (op_q)
      3'b000:                 fin_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
      3'b100, 3'b101:         fin_res = quo_fin;
      3'b110, 3'b111:         fin_res = rem_fin;
`endif
      default:                fin_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = special ? StFinish : StCalc;
      end
      StCalc: begin
        if (kill)               state_d = StIdle;
        else if (cnt_q == 5'd31) state_d = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // done is registered, so busy must also cover the done cycle to block a start there
  always_comb begin
    busy   = (state_q != StIdle) || done_q;
    done   = done_q;
    result = result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_q     <= '0;
      neg_rem_q <= 1'b0;
`endif
    end else if (accept) begin
      op_q      <= funct3;
      cnt_q     <= '0;
      a_q       <= funct3[2] ? b_mag : a_mag;
      acc_q     <= {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
      neg_res_q <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
      rem_q     <= '0;
      neg_rem_q <= a_neg;
      // Special cases are preloaded so the normal FINISH select yields the fixed answer
      if (div_zero) begin
        acc_q     <= {{XLEN{1'b0}}, {XLEN{1'b1}}};
        rem_q     <= rs1_val;
        neg_res_q <= 1'b0;
        neg_rem_q <= 1'b0;
      end else if (div_ovf) begin
        acc_q     <= {{XLEN{1'b0}}, SignMin};
        neg_res_q <= 1'b0;
        neg_rem_q <= 1'b0;
      end
`else
      if (special) begin
        acc_q     <= '0;
        neg_res_q <= 1'b0;
      end
`endif
    end else if (state_q == StCalc) begin
      cnt_q <= cnt_q + 5'd1;
`ifdef MULDIV_DIV_EN
      if (op_q[2]) begin
        rem_q             <= rem_d;
        acc_q[XLEN-1:0]   <= {acc_q[XLEN-2:0], div_ok};
      end else begin
        acc_q <= mul_next;
      end
`else
      acc_q <= mul_next;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= (state_q == StFinish) && !kill;
      if ((state_q == StFinish) && !kill) result_q <= fin_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; expected values follow the MULDIV_DIV_EN build.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1_val = '0;
  logic [31:0] rs2_val = '0;
  logic        busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kill   (kill),
    .funct3 (funct3),
    .rs1_val(rs1_val),
    .rs2_val(rs2_val),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  // Issue one operation and wait (bounded) for done; lat counts cycles after the accepting edge
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res, output logic busy_ok);
    @(negedge clk);
    funct3 = f; rs1_val = a; rs2_val = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    if (!done) lat = -1;
    res = result;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    logic [2:0]  fs [3];
    logic [31:0] ex [3];
    int lat; logic [31:0] res; logic bok;
    fs[0] = 3'b000; ex[0] = 32'hFFFF_FFEB;
    fs[1] = 3'b001; ex[1] = 32'hFFFF_FFFF;
    fs[2] = 3'b011; ex[2] = 32'h0000_0006;
    for (int i = 0; i < 3; i++) begin
      run_op(fs[i], 32'd7, 32'hFFFF_FFFD, lat, res, bok);
      checks++;
      if (res !== ex[i]) begin errors++; $display("FAIL mul_res f3=%b got %h want %h", fs[i], res, ex[i]); end
      checks++;
      if (lat != 34) begin errors++; $display("FAIL mul_lat f3=%b got %0d want 34", fs[i], lat); end
      checks++;
      if (!bok) begin errors++; $display("FAIL mul_busy f3=%b got low want high", fs[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  fs [3];
    logic [31:0] av [3], bv [3], ex [3];
    int el;
    int lat; logic [31:0] res; logic bok;
    fs[0] = 3'b100; av[0] = 32'hFFFF_FFF9; bv[0] = 32'd2;
    fs[1] = 3'b110; av[1] = 32'hFFFF_FFF9; bv[1] = 32'd2;
    fs[2] = 3'b101; av[2] = 32'd100;       bv[2] = 32'd7;
`ifdef MULDIV_DIV_EN
    ex[0] = 32'hFFFF_FFFD; ex[1] = 32'hFFFF_FFFF; ex[2] = 32'd14; el = 34;
`else
    ex[0] = 32'h0; ex[1] = 32'h0; ex[2] = 32'h0; el = 2;
`endif
    for (int i = 0; i < 3; i++) begin
      run_op(fs[i], av[i], bv[i], lat, res, bok);
      checks++;
      if (res !== ex[i]) begin errors++; $display("FAIL div_res f3=%b got %h want %h", fs[i], res, ex[i]); end
      checks++;
      if (lat != el) begin errors++; $display("FAIL div_lat f3=%b got %0d want %0d", fs[i], lat, el); end
    end
  endtask

  task automatic test_special();
    logic [2:0]  fs [4];
    logic [31:0] av [4], bv [4], ex [4];
    int lat; logic [31:0] res; logic bok;
    fs[0] = 3'b101; av[0] = 32'd5;         bv[0] = 32'd0;
    fs[1] = 3'b110; av[1] = 32'h8000_0000; bv[1] = 32'hFFFF_FFFF;
    fs[2] = 3'b100; av[2] = 32'h8000_0000; bv[2] = 32'hFFFF_FFFF;
    fs[3] = 3'b111; av[3] = 32'h0000_1234; bv[3] = 32'd0;
`ifdef MULDIV_DIV_EN
    ex[0] = 32'hFFFF_FFFF; ex[1] = 32'h0; ex[2] = 32'h8000_0000; ex[3] = 32'h0000_1234;
`else
    ex[0] = 32'h0; ex[1] = 32'h0; ex[2] = 32'h0; ex[3] = 32'h0;
`endif
    for (int i = 0; i < 4; i++) begin
      run_op(fs[i], av[i], bv[i], lat, res, bok);
      checks++;
      if (res !== ex[i]) begin errors++; $display("FAIL special_res f3=%b got %h want %h", fs[i], res, ex[i]); end
      checks++;
      if (lat != 2) begin errors++; $display("FAIL special_lat f3=%b got %0d want 2", fs[i], lat); end
    end
  endtask

  task automatic test_kill();
    int lat; logic [31:0] res; logic bok; logic saw_done;
    run_op(3'b011, 32'd7, 32'hFFFF_FFFD, lat, res, bok);  // result now 6
    // kill with start in the same idle cycle: nothing accepted
    @(negedge clk);
    funct3 = 3'b000; rs1_val = 32'd3; rs2_val = 32'd5; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL kill_start_busy got %b want 0", busy); end
    // kill mid-multiply
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    saw_done = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (done) saw_done = 1'b1;
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0 || saw_done) begin errors++; $display("FAIL kill_done got %b want 0", done); end
    checks++;
    if (result !== 32'd6) begin errors++; $display("FAIL kill_result got %h want 00000006", result); end
    run_op(3'b000, 32'd3, 32'd5, lat, res, bok);
    checks++;
    if (res !== 32'd15) begin errors++; $display("FAIL kill_restart_res got %h want 0000000f", res); end
    checks++;
    if (lat != 34) begin errors++; $display("FAIL kill_restart_lat got %0d want 34", lat); end
  endtask

  task automatic test_back_to_back();
    int lat, n;
    @(negedge clk);
    funct3 = 3'b000; rs1_val = 32'd7; rs2_val = 32'hFFFF_FFFD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 5) begin
        funct3 = 3'b011; rs1_val = 32'd1; rs2_val = 32'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    checks++;
    if (lat != 34 || !done) begin errors++; $display("FAIL busy_start_lat got %0d want 34", lat); end
    checks++;
    if (result !== 32'hFFFF_FFEB) begin errors++; $display("FAIL busy_start_res got %h want ffffffeb", result); end
    // start raised in the done cycle; only the following idle cycle may accept it
    funct3 = 3'b010; rs1_val = 32'hFFFF_FFFF; rs2_val = 32'hFFFF_FFFF; start = 1'b1;
    @(negedge clk);
    n = 1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b want 0", busy); end
    @(negedge clk);
    n = 2;
    start = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 35 || !done) begin errors++; $display("FAIL b2b_lat got %0d want 35", n); end
    checks++;
    if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_res got %h want ffffffff", result); end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    @(negedge clk);
    funct3 = 3'b000; rs1_val = 32'd7; rs2_val = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
    checks++;
    if (result !== 32'h0) begin errors++; $display("FAIL midreset_result got %h want 0", result); end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL midreset_after got activity want idle"); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
